// File: rtl/ttl_bus_sequencer.sv
// Round-robin transfer sequencer for a shared tri-state bus of octal D registers.
// Each granted transfer drives one source OE_bar low for DRIVE and LATCH and
// pulses the destination capture clock in LATCH. A TURN cycle with every
// output enable high always separates two bus drivers.
module ttl_bus_sequencer #(
  parameter int N_REG = 4,
  parameter int N_REQ = 3,
  localparam int SELW = (N_REG > 1) ? $clog2(N_REG) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*SELW-1:0]  req_src,
  input  logic [N_REQ*SELW-1:0]  req_dst,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       err,
  output logic [N_REG-1:0]       OE_bar,
  output logic [N_REG-1:0]       LD_CLK,
  output logic                   bus_busy
);

  localparam int PTRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, TURN} state_t;

  state_t            state, state_nxt;
  logic [PTRW-1:0]   ptr, ptr_nxt;
  logic [PTRW-1:0]   gnt_idx, gnt_q;
  logic              gnt_found;
  logic [SELW-1:0]   win_src, win_dst, src_q, dst_q, src_nxt;
  logic              win_bad, arb, grant_ok, reject;
  logic [N_REG-1:0]  oe_nxt, ld_nxt;
  logic [N_REQ-1:0]  ack_nxt, err_nxt;
  logic              busy_nxt;

  // Round-robin scan: lowest rotation offset from the pointer with a valid request wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!gnt_found && req_valid[i] &&
            (((32'(ptr) + k) % 32'(N_REQ)) == i)) begin
          gnt_found = 1'b1;
          gnt_idx   = PTRW'(i);
        end
      end
    end
    win_src = req_src[32'(gnt_idx)*SELW +: SELW];
    win_dst = req_dst[32'(gnt_idx)*SELW +: SELW];
    win_bad = (32'(win_src) >= 32'(N_REG)) || (32'(win_dst) >= 32'(N_REG));
  end

  // State register: FSM state, pointer, latched grant and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      OE_bar   <= '1;
      LD_CLK   <= '0;
      ack      <= '0;
      err      <= '0;
      bus_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      if (grant_ok) begin
        gnt_q <= gnt_idx;
        src_q <= win_src;
        dst_q <= win_dst;
      end
      OE_bar   <= oe_nxt;
      LD_CLK   <= ld_nxt;
      ack      <= ack_nxt;
      err      <= err_nxt;
      bus_busy <= busy_nxt;
    end
  end

  // Next-state logic: arbitration only in IDLE and TURN, rejects fall back to IDLE.
  always_comb begin
    arb       = ((state == IDLE) || (state == TURN)) && gnt_found;
    grant_ok  = arb && !win_bad;
    reject    = arb && win_bad;
    ptr_nxt   = arb ? PTRW'((32'(gnt_idx) + 32'd1) % 32'(N_REQ)) : ptr;
    src_nxt   = grant_ok ? win_src : src_q;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant_ok ? DRIVE : IDLE;
      DRIVE:   state_nxt = LATCH;
      LATCH:   state_nxt = TURN;
      TURN:    state_nxt = grant_ok ? DRIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so every output is a plain flop that
  // lines up with the state it describes (DRIVE/LATCH/TURN cycle itself).
  always_comb begin
    oe_nxt   = '1;
    ld_nxt   = '0;
    ack_nxt  = '0;
    err_nxt  = '0;
    busy_nxt = (state_nxt != IDLE);
    if (reject) err_nxt[gnt_idx] = 1'b1;
    if ((state_nxt == DRIVE) || (state_nxt == LATCH)) oe_nxt[src_nxt] = 1'b0;
    if (state_nxt == LATCH) begin
      ld_nxt[dst_q] = 1'b1;
      ack_nxt[gnt_q] = 1'b1;
    end
  end

endmodule

// File: doc/ttl_bus_sequencer.md
# ttl_bus_sequencer

Sequencer and arbiter for a shared tri-state data bus populated by octal D-flip-flop register chips with active-low output enables. It accepts register-to-register transfer requests from several requesters and grants them round-robin. For each grant it drives exactly one register's OE_bar low and pulses the destination register's capture clock. A mandatory turnaround cycle separates bus drivers so two registers never drive the bus at once.

## Interface

- N_REG, 4: number of bus registers controlled; SELW = clog2(N_REG), minimum 1.
- N_REQ, 3: number of requesters.
- CLK  in  1  single system clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester transfer request; held until that requester's ack.
- req_src  in  N_REQ*SELW  packed source register index; requester i occupies bits [i*SELW +: SELW].
- req_dst  in  N_REQ*SELW  packed destination register index, same packing.
- ack  out  N_REQ  one-cycle pulse when requester i's transfer completes.
- err  out  N_REQ  one-cycle pulse when requester i's request is rejected.
- OE_bar  out  N_REG  active-low output enables, one per register; at most one bit is low.
- LD_CLK  out  N_REG  capture clock, one per register; the register captures on the rising edge.
- bus_busy  out  1  high in every state except IDLE.

## Operation

- All outputs are registered. Reset values: OE_bar all 1, LD_CLK all 0, ack 0, err 0, bus_busy 0, state IDLE, round-robin pointer 0.
- States: IDLE, DRIVE, LATCH, TURN.
- Arbitration is evaluated in IDLE and in TURN.
  - Scan starts at the pointer and runs upward modulo N_REQ; the first i with req_valid[i] wins.
  - After a grant to i, the pointer becomes (i+1) mod N_REQ.
  - Grant index, src and dst are latched at the grant edge.
- Rejection: if the winner's src or dst is >= N_REG, err[i] pulses for one cycle instead of a transfer.
  - State stays or returns to IDLE; the pointer still advances.
  - No OE_bar or LD_CLK activity occurs.
- IDLE: a valid grant moves the state to DRIVE. No requests means stay in IDLE.
- DRIVE: OE_bar[src] = 0, all other OE_bar bits 1, LD_CLK all 0. Next state LATCH.
- LATCH: OE_bar[src] stays 0 and LD_CLK[dst] = 1, so the destination captures at the start of LATCH with bus data stable for one full cycle. ack[i] = 1. Next state TURN.
- TURN: OE_bar all 1, LD_CLK all 0.
  - A valid grant goes directly to DRIVE.
  - A rejected grant pulses err and goes to IDLE.
  - No request goes to IDLE.
- src == dst is legal: the register reloads itself, and OE_bar[src] and LD_CLK[src] are both active in LATCH.
- Dropping req_valid after a grant does not abort the transfer; the transfer completes and ack still pulses.
- A requester must not reassert a new request in the cycle its ack is high; the arbiter in TURN already sees the deasserted value.

## Timing

- Grant edge t (IDLE to DRIVE): OE_bar[src] low during t+1; LD_CLK[dst] rises at t+2; ack during t+2; OE_bar all high at t+3 (TURN).
- Request-to-ack latency from IDLE is 2 cycles after the grant edge, i.e. 3 edges after req_valid is first seen.
- Back-to-back throughput is one transfer per 3 cycles (DRIVE, LATCH, TURN).
- Bus contention invariant: there is never a cycle with more than one OE_bar bit low. At least one all-high cycle (TURN) separates distinct drivers.
- LD_CLK is high for exactly one cycle per transfer and only in LATCH.
- Reset asserted in any state: at the next edge all outputs return to reset values and any in-flight transfer is discarded without ack. RST has priority over all transitions.

## Test plan

- Reset: hold RST 2 cycles with req_valid=3'b111 → OE_bar=4'b1111, LD_CLK=0, ack=0, bus_busy=0 throughout; the first grant goes to requester 0 after RST deasserts.
- Single transfer: req_valid[1]=1, src=2, dst=0 in IDLE at edge t → OE_bar=4'b1011 in t+1 and t+2; LD_CLK=4'b0001 and ack=3'b010 in t+2; OE_bar=4'b1111 in t+3.
- Round robin: all three requesters held valid with distinct src/dst → acks in order 0,1,2,0 spaced 3 cycles apart; a checker confirms no cycle has two OE_bar bits low and a TURN cycle sits between drivers.
- Self transfer: src=dst=3 → OE_bar=4'b0111 and LD_CLK=4'b1000 coincide in LATCH; ack pulses once.
- Rejection: N_REG=3 with src=3 → err pulses for that requester 1 cycle after the grant decision; OE_bar and LD_CLK never change; the pointer advances to the next requester.
- Reset mid-transfer: assert RST during LATCH → next cycle OE_bar all 1, LD_CLK 0, no further ack, state IDLE.
